// File: rtl/arb8_rr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arb_pkg
// Purpose  : Shared constants and state encoding for the 8-way RR arbiter.
// Revision : 1.0  initial release
// ============================================================================
package arb_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage : arb_pkg
`default_nettype wire

// File: rtl/arb8_rr_if.sv
`default_nettype none
// ============================================================================
// Module   : arb8_rr_if
// Purpose  : Request/grant bundle between requesters and the RR arbiter.
// Revision : 1.0  initial release
// ============================================================================
interface arb8_rr_if;
  import arb_pkg::*;

  logic [N_REQ-1:0] iReq;
  logic             iEn;
  logic [N_REQ-1:0] oGnt;
  logic [IDX_W-1:0] oGntIdx;
  logic             oValid;

  modport master (
    output iReq,
    output iEn,
    input  oGnt,
    input  oGntIdx,
    input  oValid
  );

  modport slave (
    input  iReq,
    input  iEn,
    output oGnt,
    output oGntIdx,
    output oValid
  );

endinterface : arb8_rr_if
`default_nettype wire

// File: rtl/onehot_enc8.sv
`default_nettype none
// ============================================================================
// Module   : onehot_enc8
// Purpose  : 8-bit one-hot to 3-bit binary encoder; all-zero input gives 0.
// Revision : 1.0  initial release
// ============================================================================
module onehot_enc8 (
  input  wire logic [7:0] onehot_i,
  output logic      [2:0] idx_o
);

  assign idx_o = {|(onehot_i & 8'hF0), |(onehot_i & 8'hCC), |(onehot_i & 8'hAA)};

endmodule : onehot_enc8
`default_nettype wire

// File: rtl/arb8_rr.sv
`default_nettype none
// ============================================================================
// Module   : arb8_rr
// Purpose  : 8-requester round-robin arbiter with hold-limit timeout and
//            registered one-hot grant, binary index and valid flag.
// Revision : 1.0  initial release
// ============================================================================
module arb8_rr
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  wire logic iClk,
  input  wire logic iRst,
  arb8_rr_if.slave  bus
);

  state_t             state_q;
  logic [N_REQ-1:0]   gnt_q;
  logic [N_REQ-1:0]   gnt_d;
  logic [IDX_W-1:0]   idx_q;
  logic [IDX_W-1:0]   idx_d;
  logic               valid_q;
  logic [IDX_W-1:0]   ptr_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [2*N_REQ-1:0] req_dbl;
  logic [N_REQ-1:0]   req_rot;
  logic [IDX_W-1:0]   off;
  logic [IDX_W-1:0]   win;
  logic               found;
  logic               rel;

  // Rotate so the pointer position lands at bit 0, then take the lowest set bit.
  always_comb begin
    req_dbl = {bus.iReq, bus.iReq};
    req_rot = N_REQ'(req_dbl >> ptr_q);
    found   = 1'b0;
    off     = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (!found && req_rot[j]) begin
        found = 1'b1;
        off   = IDX_W'(j);
      end
    end
    win   = ptr_q + off;
    gnt_d = '0;
    if ((state_q == IDLE) && bus.iEn && found) begin
      gnt_d[win] = 1'b1;
    end
  end

  onehot_enc8 u_enc (
    .onehot_i (gnt_d),
    .idx_o    (idx_d)
  );

  assign rel = !bus.iReq[idx_q] || (cnt_q == CNT_W'(MAX_HOLD));

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|gnt_d) begin
            state_q <= GRANT;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            valid_q <= 1'b1;
            cnt_q   <= CNT_W'(1);
          end
        end
        GRANT: begin
          // Pointer moves past the winner on any release, including timeout.
          if (rel) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            ptr_q   <= idx_q + IDX_W'(1);
            cnt_q   <= '0;
          end else begin
            cnt_q   <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= '0;
          idx_q   <= '0;
          valid_q <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign bus.oGnt    = gnt_q;
  assign bus.oGntIdx = idx_q;
  assign bus.oValid  = valid_q;

endmodule : arb8_rr
`default_nettype wire

// File: tb/tb_arb8_rr.sv
`default_nettype none
// ============================================================================
// Module   : tb_arb8_rr
// Purpose  : Directed and randomised self-checking bench for arb8_rr.
// Revision : 1.0  initial release
// ============================================================================
module tb_arb8_rr;
  import arb_pkg::*;

  localparam int MAX_HOLD = 4;
  localparam int WAIT_MAX = 8 * (MAX_HOLD + 1);

  logic iClk;
  logic iRst;
  int   n_assert;
  int   n_fail;
  int   w [8];
  logic [7:0] rq;

  arb8_rr_if bus ();

  arb8_rr #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
    .iClk (iClk),
    .iRst (iRst),
    .bus  (bus)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [7:0] g);
    logic [31:0] r;
    r = 0;
    for (int i = 0; i < 8; i++) if (g[i]) r = i;
    return r;
  endfunction

  task automatic chk_out(input string tag, input logic [31:0] g, input logic [31:0] idx);
    chk({tag, "_gnt"}, 32'(bus.oGnt), g);
    chk({tag, "_idx"}, 32'(bus.oGntIdx), idx);
    chk({tag, "_vld"}, 32'(bus.oValid), (g != 0) ? 1 : 0);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    iRst     = 1'b1;
    bus.iReq = 8'h00;
    bus.iEn  = 1'b0;
    tick();
    tick();
    iRst = 1'b0;
    chk_out("reset", 0, 0);
    chk("reset_ptr", 32'(dut.ptr_q), 0);
    chk("reset_cnt", 32'(dut.cnt_q), 0);

    // Single requester, one-cycle latency, pointer advances past it.
    bus.iEn  = 1'b1;
    bus.iReq = 8'h04;
    tick();
    chk_out("single", 'h04, 2);
    chk("single_cnt", 32'(dut.cnt_q), 1);
    bus.iReq = 8'h00;
    tick();
    chk_out("single_rel", 0, 0);
    chk("single_ptr", 32'(dut.ptr_q), 3);

    // Everyone requesting: order follows pointer with one bubble between grants.
    for (int s = 0; s < 8; s++) begin
      bus.iReq = 8'hFF;
      tick();
      chk_out("rr", 32'(1) << ((3 + s) % 8), (3 + s) % 8);
      rq = 8'hFF;
      rq[(3 + s) % 8] = 1'b0;
      bus.iReq = rq;
      tick();
      chk_out("rr_bubble", 0, 0);
    end
    chk("rr_ptr", 32'(dut.ptr_q), 3);

    // Timeout: reset pointer to 0 then hold both 0 and 7.
    iRst     = 1'b1;
    bus.iReq = 8'h00;
    tick();
    iRst     = 1'b0;
    bus.iReq = 8'h81;
    for (int c = 1; c <= MAX_HOLD; c++) begin
      tick();
      chk_out("to0", 'h01, 0);
      chk("to0_cnt", 32'(dut.cnt_q), c);
    end
    tick();
    chk_out("to0_bubble", 0, 0);
    chk("to0_ptr", 32'(dut.ptr_q), 1);
    for (int c = 1; c <= MAX_HOLD; c++) begin
      tick();
      chk_out("to7", 'h80, 7);
    end
    tick();
    chk_out("to7_bubble", 0, 0);
    chk("to7_ptr", 32'(dut.ptr_q), 0);
    tick();
    chk_out("to_regrant0", 'h01, 0);
    bus.iReq = 8'h00;
    tick();
    chk_out("to_rel", 0, 0);

    // Enable gating: no grant while disabled, grant survives enable dropping.
    bus.iEn  = 1'b0;
    bus.iReq = 8'h10;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk_out("en_off", 0, 0);
    end
    bus.iEn = 1'b1;
    tick();
    chk_out("en_on", 'h10, 4);
    bus.iEn = 1'b0;
    tick();
    chk_out("en_hold1", 'h10, 4);
    tick();
    chk_out("en_hold2", 'h10, 4);
    bus.iReq = 8'h00;
    tick();
    chk_out("en_rel", 0, 0);
    chk("en_ptr", 32'(dut.ptr_q), 5);

    // Reset in the middle of a grant.
    bus.iEn  = 1'b1;
    bus.iReq = 8'h20;
    tick();
    chk_out("mid", 'h20, 5);
    iRst     = 1'b1;
    bus.iReq = 8'h22;
    tick();
    chk_out("mid_rst", 0, 0);
    chk("mid_rst_ptr", 32'(dut.ptr_q), 0);
    iRst = 1'b0;
    tick();
    chk_out("mid_after", 'h02, 1);
    bus.iReq = 8'h00;
    tick();

    // Random traffic with sticky requests: invariants and bounded waiting.
    for (int k = 0; k < 8; k++) w[k] = 0;
    rq = 8'h00;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      tick();
      chk("inv_onehot", 32'($onehot0(bus.oGnt)), 1);
      chk("inv_valid", 32'(bus.oValid), 32'(|bus.oGnt));
      chk("inv_idx", 32'(bus.oGntIdx), enc(bus.oGnt));
      if (dut.state_q == GRANT) chk("inv_cnt", 32'(dut.cnt_q <= 8'(MAX_HOLD)), 1);
      for (int k = 0; k < 8; k++) begin
        if (bus.oGnt[k]) w[k] = 0;
        else if (bus.iReq[k] && bus.iEn) w[k]++;
        else w[k] = 0;
        chk("wait_bound", 32'(w[k] <= WAIT_MAX), 1);
      end
      for (int k = 0; k < 8; k++) begin
        if (rq[k] && bus.oGnt[k]) rq[k] = ($urandom_range(2) != 0);
        else if (!rq[k])          rq[k] = ($urandom_range(3) == 0);
      end
      bus.iReq = rq;
      bus.iEn  = ($urandom_range(15) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_arb8_rr
`default_nettype wire
